// File: rtl/bank_fsm_gen.sv
// bank_fsm_gen: single-bank DRAM command sequencer.
// Accepts one request at a time and issues ACT / RD / WR / PRE / REF while
// honouring tRCD, tRP and tRFC. Tracks owed refreshes and forces a refresh
// once MAX_POSTPONE of them are owed. The scheduler may stall the bank at any
// time; a stall freezes the state and every timing counter.
// Optional build macro PARTIAL_REFRESH_SKIP_EN: tracks the highest row
// written in each quarter of the row space. A refresh whose target row lies
// above that mark is replaced by a NOP and reported on refresh_skipped.
module bank_fsm_gen #(
    parameter int ROW_W        = 16,
    parameter int COL_W        = 10,
    parameter int TREFI        = 3900,
    parameter int TRFC         = 260,
    parameter int TRCD         = 3,
    parameter int TRP          = 3,
    parameter int MAX_POSTPONE = 2,
    parameter int PAGE_POLICY  = 0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         init_done,
    input  logic                                         stall,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic                                         req_rw,
    input  logic [ROW_W-1:0]                             req_row,
    input  logic [COL_W-1:0]                             req_col,
    input  logic                                         req_ap,
    output logic                                         issue_valid,
    output logic [2:0]                                   issue_cmd,
    output logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] issue_addr,
    output logic [2:0]                                   ref_pending,
    output logic                                         row_open,
    output logic [ROW_W-1:0]                             open_row,
    output logic                                         refresh_skipped
);

    localparam int AW     = (ROW_W > COL_W) ? ROW_W : COL_W;
    localparam int TMAX_A = (TRCD > TRP) ? TRCD : TRP;
    localparam int TMAX   = (TMAX_A > TRFC) ? TMAX_A : TRFC;
    localparam int CNT_W  = $clog2(TMAX + 1);
    localparam int REF_CW = $clog2(TREFI + 1);

    // Wait counters are loaded with (cycles - 1) and count down to zero.
    localparam logic [CNT_W-1:0]  RCD_LOAD = (TRCD > 1) ? CNT_W'(TRCD - 2) : CNT_W'(0);
    localparam logic [CNT_W-1:0]  RP_LOAD  = (TRP > 1)  ? CNT_W'(TRP - 2)  : CNT_W'(0);
    localparam logic [CNT_W-1:0]  RFC_LOAD = CNT_W'(TRFC - 1);
    localparam logic [REF_CW-1:0] REF_LAST = REF_CW'(TREFI - 1);
    localparam logic [2:0]        PEND_MAX = 3'(MAX_POSTPONE);

    localparam logic [3:0] ST_INIT       = 4'd0;
    localparam logic [3:0] ST_IDLE       = 4'd1;
    localparam logic [3:0] ST_ACT        = 4'd2;
    localparam logic [3:0] ST_RCD_WAIT   = 4'd3;
    localparam logic [3:0] ST_RW         = 4'd4;
    localparam logic [3:0] ST_STANDBY    = 4'd5;
    localparam logic [3:0] ST_PRE        = 4'd6;
    localparam logic [3:0] ST_RP_WAIT    = 4'd7;
    localparam logic [3:0] ST_REF        = 4'd8;
    localparam logic [3:0] ST_REFRESHING = 4'd9;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic [3:0]        state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [REF_CW-1:0] ref_cnt_reg;
    logic [2:0]        ref_pending_reg, ref_pending_next;
    logic              buf_rw_reg, buf_ap_reg, miss_pending_reg;
    logic [ROW_W-1:0]  buf_row_reg;
    logic [COL_W-1:0]  buf_col_reg;
    logic              row_open_reg;
    logic [ROW_W-1:0]  open_row_reg;

    logic       forced;
    logic       handshake;
    logic       row_hit;
    logic       act_fire, rw_fire, pre_fire;
    logic       ref_state_go, ref_fire, skip_fire, ref_served;
    logic       ref_tick;
    logic       skip;
    logic [3:0] after_pre_state;

    assign forced    = (ref_pending_reg == PEND_MAX);
    assign req_ready = ((state_reg == ST_IDLE) || (state_reg == ST_STANDBY)) && !stall && !forced;
    assign handshake = req_valid && req_ready;
    assign row_hit   = (req_row == open_row_reg);

    assign act_fire     = (state_reg == ST_ACT) && !stall;
    assign rw_fire      = (state_reg == ST_RW)  && !stall;
    assign pre_fire     = (state_reg == ST_PRE) && !stall;
    assign ref_state_go = (state_reg == ST_REF) && !stall;
    assign ref_fire     = ref_state_go && !skip;
    assign skip_fire    = ref_state_go && skip;
    assign ref_served   = ref_state_go;
    assign ref_tick     = (state_reg != ST_INIT) && !stall && (ref_cnt_reg == REF_LAST);

    assign ref_pending     = ref_pending_reg;
    assign row_open        = row_open_reg;
    assign open_row        = open_row_reg;
    assign refresh_skipped = skip_fire;

`ifdef PARTIAL_REFRESH_SKIP_EN
    logic [ROW_W-1:0] tracker_reg;
    logic [3:0]       seg_skip;
    logic [1:0]       trk_seg;
    logic [ROW_W-3:0] trk_off;
    logic             wr_fire;
    logic [1:0]       wr_seg;
    logic [ROW_W-3:0] wr_off;

    assign trk_seg = tracker_reg[ROW_W-1:ROW_W-2];
    assign trk_off = tracker_reg[ROW_W-3:0];
    assign wr_fire = rw_fire && !buf_rw_reg;
    assign wr_seg  = buf_row_reg[ROW_W-1:ROW_W-2];
    assign wr_off  = buf_row_reg[ROW_W-3:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seg
            logic             seg_valid_reg;
            logic [ROW_W-3:0] seg_ptr_reg;

            // Raise this segment's high-water mark on every write beyond it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    seg_valid_reg <= 1'b0;
                    seg_ptr_reg   <= '0;
                end else if (wr_fire && (wr_seg == 2'(gi)) &&
                             (!seg_valid_reg || (wr_off > seg_ptr_reg))) begin
                    seg_valid_reg <= 1'b1;
                    seg_ptr_reg   <= wr_off;
                end
            end

            // A never-written segment holds no data, so all its rows are skippable.
            assign seg_skip[gi] = !seg_valid_reg || (trk_off > seg_ptr_reg);
        end
    endgenerate

    // Row tracker walks through the array once per served refresh slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tracker_reg <= '0;
        end else if (ref_served) begin
            tracker_reg <= tracker_reg + 1'b1;
        end
    end

    assign skip = seg_skip[trk_seg];
`else
    assign skip = 1'b0;
`endif

    // Destination after a precharge completes: buffered miss first, then a forced refresh.
    always_comb begin
        if (miss_pending_reg) begin
            after_pre_state = ST_ACT;
        end else if (forced) begin
            after_pre_state = ST_REF;
        end else begin
            after_pre_state = ST_IDLE;
        end
    end

    // Next-state and wait-counter logic; a stall leaves both untouched.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        if (!stall) begin
            case (state_reg)
                ST_INIT: begin
                    if (init_done) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (forced) begin
                        state_next = ST_REF;
                    end else if (handshake) begin
                        state_next = ST_ACT;
                    end else if ((ref_pending_reg != 3'd0) && !req_valid) begin
                        state_next = ST_REF;
                    end
                end
                ST_ACT: begin
                    if (TRCD > 1) begin
                        state_next    = ST_RCD_WAIT;
                        wait_cnt_next = RCD_LOAD;
                    end else begin
                        state_next = ST_RW;
                    end
                end
                ST_RCD_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_next = ST_RW;
                    end else begin
                        wait_cnt_next = wait_cnt_reg - 1'b1;
                    end
                end
                ST_RW: begin
                    if (buf_ap_reg || (PAGE_POLICY == 1)) begin
                        state_next = ST_PRE;
                    end else begin
                        state_next = ST_STANDBY;
                    end
                end
                ST_STANDBY: begin
                    if (forced) begin
                        state_next = ST_PRE;
                    end else if (handshake) begin
                        state_next = row_hit ? ST_RW : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (TRP > 1) begin
                        state_next    = ST_RP_WAIT;
                        wait_cnt_next = RP_LOAD;
                    end else begin
                        state_next = after_pre_state;
                    end
                end
                ST_RP_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_next = after_pre_state;
                    end else begin
                        wait_cnt_next = wait_cnt_reg - 1'b1;
                    end
                end
                ST_REF: begin
                    if (skip) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_REFRESHING;
                        wait_cnt_next = RFC_LOAD;
                    end
                end
                ST_REFRESHING: begin
                    if (wait_cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

    // Owed-refresh count: a new tick and a served refresh in one cycle cancel out.
    always_comb begin
        ref_pending_next = ref_pending_reg;
        if (ref_tick && !ref_served) begin
            if (ref_pending_reg < PEND_MAX) begin
                ref_pending_next = ref_pending_reg + 3'd1;
            end
        end else if (!ref_tick && ref_served) begin
            if (ref_pending_reg != 3'd0) begin
                ref_pending_next = ref_pending_reg - 3'd1;
            end
        end
    end

    // State, wait counter and refresh bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_INIT;
            wait_cnt_reg    <= '0;
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 3'd0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            ref_pending_reg <= ref_pending_next;
            if (state_reg == ST_INIT) begin
                ref_cnt_reg <= '0;
            end else if (!stall) begin
                ref_cnt_reg <= (ref_cnt_reg == REF_LAST) ? '0 : ref_cnt_reg + 1'b1;
            end
        end
    end

    // Request buffer: captured on handshake, miss flag cleared once its ACT goes out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rw_reg       <= 1'b0;
            buf_ap_reg       <= 1'b0;
            buf_row_reg      <= '0;
            buf_col_reg      <= '0;
            miss_pending_reg <= 1'b0;
        end else begin
            if (handshake) begin
                buf_rw_reg  <= req_rw;
                buf_ap_reg  <= req_ap;
                buf_row_reg <= req_row;
                buf_col_reg <= req_col;
            end
            if (handshake && (state_reg == ST_STANDBY) && !row_hit) begin
                miss_pending_reg <= 1'b1;
            end else if (act_fire) begin
                miss_pending_reg <= 1'b0;
            end
        end
    end

    // Open-row tracker follows issued ACT and PRE commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_open_reg <= 1'b0;
            open_row_reg <= '0;
        end else if (act_fire) begin
            row_open_reg <= 1'b1;
            open_row_reg <= buf_row_reg;
        end else if (pre_fire) begin
            row_open_reg <= 1'b0;
        end
    end

    // Command decode: issuing states drive their command only on non-stalled cycles.
    always_comb begin
        issue_valid = 1'b0;
        issue_cmd   = CMD_NOP;
        issue_addr  = '0;
        if (!stall) begin
            case (state_reg)
                ST_ACT: begin
                    issue_valid = 1'b1;
                    issue_cmd   = CMD_ACT;
                    issue_addr  = AW'(buf_row_reg);
                end
                ST_RW: begin
                    issue_valid = 1'b1;
                    issue_cmd   = buf_rw_reg ? CMD_RD : CMD_WR;
                    issue_addr  = AW'(buf_col_reg);
                end
                ST_PRE: begin
                    issue_valid = 1'b1;
                    issue_cmd   = CMD_PRE;
                end
                ST_REF: begin
                    if (ref_fire) begin
                        issue_valid = 1'b1;
                        issue_cmd   = CMD_REF;
                    end
                end
                default: begin
                    issue_valid = 1'b0;
                end
            endcase
        end
    end

endmodule
